// File: rtl/writeback_queue.sv
// Four-entry in-order writeback queue merging MDU and ALU results onto one
// register-file write port, with combinational pending-write lookup for operand reads.
module writeback_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  output logic        write_enable,
  output logic [4:0]  write_address,
  output logic [31:0] write_data,
  input  logic [4:0]  query_addr1,
  input  logic [4:0]  query_addr2,
  output logic        pending1,
  output logic        pending2,
  output logic [2:0]  fifo_count
);

  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   free_slots;
  logic               mdu_push;
  logic               alu_push;
  logic               pop;
  logic [CNT_W-1:0]   push_cnt;
  logic [PTR_W-1:0]   alu_slot;

  assign fifo_count = count;

  // Readiness looks only at the registered count; the MDU owns the last free slot.
  always_comb begin
    free_slots = CNT_W'(DEPTH) - count;
    mdu_ready  = (free_slots >= CNT_W'(1));
    alu_ready  = (free_slots >= CNT_W'(2)) ||
                 ((free_slots == CNT_W'(1)) && !mdu_valid);
  end

  // Writes to r0 complete the handshake but are dropped here.
  always_comb begin
    mdu_push = mdu_valid && mdu_ready && (mdu_addr != ADDR_W'(0));
    alu_push = alu_valid && alu_ready && (alu_addr != ADDR_W'(0));
    pop      = (count != CNT_W'(0));
    push_cnt = CNT_W'(mdu_push) + CNT_W'(alu_push);
    alu_slot = wr_ptr + PTR_W'(mdu_push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
    end else begin
      count  <= count + push_cnt - CNT_W'(pop);
      wr_ptr <= wr_ptr + PTR_W'(push_cnt);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      write_enable <= pop;
      if (pop) begin
        write_address <= mem[rd_ptr].addr;
        write_data    <= mem[rd_ptr].data;
      end
    end
  end

  // Entry storage; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (mdu_push) begin
      mem[wr_ptr] <= '{addr: mdu_addr, data: mdu_data};
    end
    if (alu_push) begin
      mem[alu_slot] <= '{addr: alu_addr, data: alu_data};
    end
  end

  // Scoreboard lookup over occupied entries plus the write currently on the port.
  always_comb begin
    pending1 = 1'b0;
    pending2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count) begin
        if (mem[rd_ptr + PTR_W'(i)].addr == query_addr1) pending1 = 1'b1;
        if (mem[rd_ptr + PTR_W'(i)].addr == query_addr2) pending2 = 1'b1;
      end
    end
    if (write_enable && (write_address == query_addr1)) pending1 = 1'b1;
    if (write_enable && (write_address == query_addr2)) pending2 = 1'b1;
    if (query_addr1 == ADDR_W'(0)) pending1 = 1'b0;
    if (query_addr2 == ADDR_W'(0)) pending2 = 1'b0;
  end

endmodule
